// File: rtl/reg_file_sb_if.sv
// Decode/issue/write-back bundle for the scoreboarded register file.
// The master drives indices and write-backs; the slave returns read data and busy state.
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            wb0_we;
    logic [AW-1:0]   wb0_rd;
    logic [XLEN-1:0] wb0_wd;
    logic            wb1_we;
    logic [AW-1:0]   wb1_rd;
    logic [XLEN-1:0] wb1_wd;
    logic [AW:0]     busy_count;

    modport master (
        output rs1, rs2, issue_valid, issue_rd,
               wb0_we, wb0_rd, wb0_wd, wb1_we, wb1_rd, wb1_wd,
        input  rv1, rv2, rs1_busy, rs2_busy, busy_count
    );

    modport slave (
        input  rs1, rs2, issue_valid, issue_rd,
               wb0_we, wb0_rd, wb0_wd, wb1_we, wb1_rd, wb1_wd,
        output rv1, rv2, rs1_busy, rs2_busy, busy_count
    );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with two write-back ports, optional write-to-read bypass
// and a per-register busy scoreboard; x0 reads as zero and is never busy.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_sb_if.slave bus
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr0_hit;
    logic [NREGS-1:0] wr1_hit;
    logic [NREGS-1:0] iss_hit;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    // Per-register next state; out-of-range indices never match any slot.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wr0_hit[gi] = 1'b0;
                assign wr1_hit[gi] = 1'b0;
                assign iss_hit[gi] = 1'b0;
                assign regs_d[gi]  = '0;
                assign busy_d[gi]  = 1'b0;
            end else begin : g_live
                assign wr0_hit[gi] = bus.wb0_we && (bus.wb0_rd == AW'(gi));
                assign wr1_hit[gi] = bus.wb1_we && (bus.wb1_rd == AW'(gi));
                assign iss_hit[gi] = bus.issue_valid && (bus.issue_rd == AW'(gi));
                assign regs_d[gi]  = wr1_hit[gi] ? bus.wb1_wd :
                                     wr0_hit[gi] ? bus.wb0_wd : regs_q[gi];
                // A new producer outranks a same-cycle write-back of the old one.
                assign busy_d[gi]  = iss_hit[gi] |
                                     (busy_q[gi] & ~(wr0_hit[gi] | wr1_hit[gi]));
            end
        end
    endgenerate

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    logic [AW-1:0]   rs_a   [2];
    logic [XLEN-1:0] rv_a   [2];
    logic            busy_a [2];

    assign rs_a[0] = bus.rs1;
    assign rs_a[1] = bus.rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic in_range;
            logic live0;
            logic live1;
            logic iss;

            assign in_range = (rs_a[gi] != '0) && (int'(rs_a[gi]) < NREGS);
            assign live1    = (BYPASS != 0) && bus.wb1_we && (bus.wb1_rd == rs_a[gi]);
            assign live0    = (BYPASS != 0) && bus.wb0_we && (bus.wb0_rd == rs_a[gi]);
            assign iss      = bus.issue_valid && (bus.issue_rd == rs_a[gi]);

            assign rv_a[gi]   = !in_range ? '0 :
                                live1     ? bus.wb1_wd :
                                live0     ? bus.wb0_wd : regs_q[rs_a[gi]];
            // A forwarded write-back resolves the hazard unless it is being re-issued.
            assign busy_a[gi] = in_range && busy_q[rs_a[gi]] && !((live0 || live1) && !iss);
        end
    endgenerate

    assign bus.rv1        = rv_a[0];
    assign bus.rv2        = rv_a[1];
    assign bus.rs1_busy   = busy_a[0];
    assign bus.rs2_busy   = busy_a[1];
    assign bus.busy_count = busy_count_q;
endmodule
